ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter RAM_BASE, default 64'h8000_0000, lowest byte address backed by RAM.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive denied fetch cycles before the fetch port is forced a grant.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  64  fetch byte address.
- if_gnt  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch response valid.
- if_rdata  out  32  instruction word.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_lock  in  1  hold port after this grant (atomic sequence).
- d_addr  in  64  data byte address.
- d_wdata  in  64  write data.
- d_wmask  in  64  bit write mask.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  data read response valid.
- d_rdata  out  64  read doubleword.
- ram_ren  out  1  RAM read enable.
- ram_ridx  out  64  RAM read doubleword index.
- ram_rdata  in  64  RAM read data, combinational from ram_ridx.
- ram_wen  out  1  RAM write enable.
- ram_widx  out  64  RAM write doubleword index.
- ram_wdata  out  64  RAM write data.
- ram_wmask  out  64  RAM write mask.

Function
REQ-004 SHALL grant at most one requester per cycle; if_gnt and d_gnt SHALL be combinational from the requests and the current state.
REQ-005 SHALL run a two-state FSM: IDLE and LOCKED. IDLE -> LOCKED on d_gnt && d_lock. LOCKED -> IDLE on the first cycle with d_req && !d_lock, which is granted. LOCKED -> IDLE when d_req = 0 (no grant that cycle).
REQ-006 In IDLE, a simultaneous if_req and d_req SHALL grant data, except as REQ-016 allows; a lone request SHALL be granted.
REQ-007 In LOCKED, if_gnt SHALL be 0 and d_req SHALL be granted every cycle.
REQ-008 Index SHALL be (addr - RAM_BASE) >> 3 for both ram_ridx and ram_widx; an address below RAM_BASE SHALL be out of range.
REQ-009 Granted in-range reads SHALL assert ram_ren in the grant cycle, register ram_rdata, and raise the matching rvalid exactly one cycle later for one cycle.
REQ-010 if_rdata SHALL be the upper 32 bits of the registered word when if_addr[2] = 1, and the lower 32 bits otherwise; the if_addr[2] used SHALL be the one captured at grant.
REQ-011 Granted in-range writes SHALL assert ram_wen with d_wdata/d_wmask in the grant cycle and SHALL produce no d_rvalid.
REQ-012 Out-of-range grants SHALL keep ram_ren/ram_wen at 0; out-of-range reads SHALL still give rvalid one cycle later with rdata = 0.
REQ-013 Requesters SHALL hold req, addr and write fields stable until their gnt; a req dropped before gnt is discarded without side effect.
REQ-014 When neither port is granted, ram_ren and ram_wen SHALL be 0 and the index/data outputs are don't-care.
REQ-015 Throughput SHALL be one grant per cycle; back-to-back grants to either port SHALL be legal.

Reset
REQ-017 On rst the FSM SHALL enter IDLE, the starvation counter SHALL clear, and if_rvalid, d_rvalid, if_rdata and d_rdata SHALL be 0.
REQ-018 A response pending when rst asserts SHALL be dropped; no rvalid follows reset.
REQ-019 While rst is high, if_gnt, d_gnt, ram_ren and ram_wen SHALL be 0.

Configuration
REQ-016 With ARB_STARVE_GUARD_EN defined:
- A saturating counter SHALL count cycles with if_req && !if_gnt and SHALL clear on if_gnt.
- When the counter equals STARVE_LIMIT in IDLE, fetch SHALL win a simultaneous conflict.
- LOCKED SHALL still block fetch.
Without ARB_STARVE_GUARD_EN, no counter SHALL exist and data always wins.

Verification
REQ-020 if_req only, if_addr = 0x8000_0004, RAM word 0x1111_2222_3333_4444 -> if_gnt in cycle 0; if_rvalid in cycle 1 with if_rdata = 0x1111_2222; ram_ridx = 0.
REQ-021 if_req and d_req (read, d_addr = 0x8000_0010) held 3 cycles -> d_gnt each cycle, if_gnt = 0; ram_ridx = 2; d_rvalid in cycles 1-3.
REQ-022 Conflict held 5 cycles with guard enabled and STARVE_LIMIT = 4 -> if_gnt in cycle 4. With the guard disabled -> if_gnt never asserts.
REQ-023 d_lock = 1 read, then d_req idle for 0 cycles, then write with d_lock = 0, while if_req is held -> if_gnt = 0 through the write cycle; if_gnt = 1 in the cycle after the write.
REQ-024 d_req write to 0x1000 -> d_gnt = 1, ram_wen = 0. d_req read to 0x1000 -> d_rvalid with d_rdata = 0.
REQ-025 rst asserted in the cycle after a read grant -> no rvalid; all outputs 0 for the following cycle.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Arbitrates an instruction-fetch port and a data port onto a single RAM
//   with one read port and one write port. At most one requester is granted
//   per cycle; grants are combinational. Read responses are registered and
//   appear one cycle after the grant. A data-side lock holds the RAM for an
//   atomic sequence.
//
//   Optional feature: define ARB_STARVE_GUARD_EN to add a starvation counter
//   that lets fetch win a conflict after STARVE_LIMIT consecutive denials.
//
// Parameters
//   RAM_BASE      lowest byte address backed by RAM
//   STARVE_LIMIT  denied fetch cycles before fetch is forced a grant
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   if_req/if_addr                    fetch request and byte address
//   if_gnt/if_rvalid/if_rdata         fetch grant, response valid, 32-bit word
//   d_req/d_we/d_lock/d_addr          data request, write, lock, byte address
//   d_wdata/d_wmask                   write data and bit mask
//   d_gnt/d_rvalid/d_rdata            data grant, read valid, 64-bit read data
//   ram_ren/ram_ridx/ram_rdata        RAM read enable, dword index, data
//   ram_wen/ram_widx/ram_wdata/ram_wmask  RAM write enable, index, data, mask
module ram_port_arbiter #(
   parameter logic [63:0] RAM_BASE     = 64'h8000_0000,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic        d_lock,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   input  logic [63:0] d_wmask,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [63:0] d_rdata,
   output logic        ram_ren,
   output logic [63:0] ram_ridx,
   input  logic [63:0] ram_rdata,
   output logic        ram_wen,
   output logic [63:0] ram_widx,
   output logic [63:0] ram_wdata,
   output logic [63:0] ram_wmask
);

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   state_t      r_state;
   logic        r_if_rvalid;
   logic [31:0] r_if_rdata;
   logic        r_d_rvalid;
   logic [63:0] r_d_rdata;

   logic        w_if_gnt;
   logic        w_d_gnt;
   logic        w_fetch_wins;
   logic        w_if_inr;
   logic        w_d_inr;
   logic [63:0] w_if_idx;
   logic [63:0] w_d_idx;
   logic        w_if_ren;
   logic        w_d_ren;
   logic        w_d_wen;

   assign w_if_inr = (if_addr >= RAM_BASE);
   assign w_d_inr  = (d_addr >= RAM_BASE);
   assign w_if_idx = (if_addr - RAM_BASE) >> 3;
   assign w_d_idx  = (d_addr - RAM_BASE) >> 3;

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] r_starve_cnt;

   assign w_fetch_wins = (r_starve_cnt == CW'(STARVE_LIMIT));

   // Saturating count of denied fetch cycles; any fetch grant clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (w_if_gnt) begin
         r_starve_cnt <= '0;
      end else if (if_req && !w_fetch_wins) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end
`else
   assign w_fetch_wins = 1'b0;
`endif

   // Grants are suppressed during reset so nothing reaches the RAM.
   always_comb begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               if (if_req && d_req) begin
                  w_if_gnt = w_fetch_wins;
                  w_d_gnt  = !w_fetch_wins;
               end else begin
                  w_if_gnt = if_req;
                  w_d_gnt  = d_req;
               end
            end
            ST_LOCKED: begin
               w_d_gnt = d_req;
            end
            default: begin
               w_if_gnt = 1'b0;
               w_d_gnt  = 1'b0;
            end
         endcase
      end
   end

   assign w_if_ren = w_if_gnt && w_if_inr;
   assign w_d_ren  = w_d_gnt && !d_we && w_d_inr;
   assign w_d_wen  = w_d_gnt && d_we && w_d_inr;

   assign if_gnt    = w_if_gnt;
   assign d_gnt     = w_d_gnt;
   assign ram_ren   = w_if_ren || w_d_ren;
   assign ram_ridx  = w_if_ren ? w_if_idx : (w_d_ren ? w_d_idx : '0);
   assign ram_wen   = w_d_wen;
   assign ram_widx  = w_d_wen ? w_d_idx : '0;
   assign ram_wdata = w_d_wen ? d_wdata : '0;
   assign ram_wmask = w_d_wen ? d_wmask : '0;

   // A response already registered when rst rises is masked so it never
   // escapes; the registers themselves clear on the same edge.
   assign if_rvalid = r_if_rvalid && !rst;
   assign if_rdata  = rst ? '0 : r_if_rdata;
   assign d_rvalid  = r_d_rvalid && !rst;
   assign d_rdata   = rst ? '0 : r_d_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_if_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rvalid  <= 1'b0;
         r_d_rdata   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_d_gnt && d_lock) begin
                  r_state <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (!d_req || !d_lock) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         r_if_rvalid <= w_if_gnt;
         r_d_rvalid  <= w_d_gnt && !d_we;

         // Half-word select uses if_addr[2] at grant, so later address
         // changes cannot affect the returned word.
         if (w_if_gnt) begin
            if (!w_if_inr) begin
               r_if_rdata <= '0;
            end else if (if_addr[2]) begin
               r_if_rdata <= ram_rdata[63:32];
            end else begin
               r_if_rdata <= ram_rdata[31:0];
            end
         end

         if (w_d_gnt && !d_we) begin
            r_d_rdata <= w_d_inr ? ram_rdata : '0;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed vectors, scoreboard queues for
// read responses, negedge monitor for rvalid outputs.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic        d_lock;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic [63:0] d_wmask;
   logic        d_gnt;
   logic        d_rvalid;
   logic [63:0] d_rdata;
   logic        ram_ren;
   logic [63:0] ram_ridx;
   logic [63:0] ram_rdata;
   logic        ram_wen;
   logic [63:0] ram_widx;
   logic [63:0] ram_wdata;
   logic [63:0] ram_wmask;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] q_if[$];
   logic [63:0] q_d[$];

   always #5 clk = ~clk;

   logic [63:0] mem [0:15] = '{
      64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFFF,
      64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF,
      64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
      64'h0, 64'h0, 64'h0, 64'h0};

   assign ram_rdata = mem[ram_ridx[3:0]];

   always @(posedge clk) begin
      if (ram_wen)
         mem[ram_widx[3:0]] <= (mem[ram_widx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
   end

   ram_port_arbiter #(
      .RAM_BASE    (64'h8000_0000),
      .STARVE_LIMIT(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_gnt   (if_gnt),
      .if_rvalid(if_rvalid),
      .if_rdata (if_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_lock   (d_lock),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_wmask  (d_wmask),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .ram_ren  (ram_ren),
      .ram_ridx (ram_ridx),
      .ram_rdata(ram_rdata),
      .ram_wen  (ram_wen),
      .ram_widx (ram_widx),
      .ram_wdata(ram_wdata),
      .ram_wmask(ram_wmask)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Response monitor: every rvalid must match the oldest expected entry.
   always @(negedge clk) begin
      logic [31:0] e32;
      logic [63:0] e64;
      if (if_rvalid === 1'b1) begin
         if (q_if.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL if_unexpected_rvalid: got rdata %h expected no response", if_rdata);
         end else begin
            e32 = q_if.pop_front();
            chk("if_rdata", {32'h0, if_rdata}, {32'h0, e32});
         end
      end
      if (d_rvalid === 1'b1) begin
         if (q_d.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL d_unexpected_rvalid: got rdata %h expected no response", d_rdata);
         end else begin
            e64 = q_d.pop_front();
            chk("d_rdata", d_rdata, e64);
         end
      end
   end

   task automatic set_if(input logic r, input logic [63:0] a);
      if_req  = r;
      if_addr = a;
   endtask

   task automatic set_d(input logic r, input logic we, input logic lk, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] wm);
      d_req   = r;
      d_we    = we;
      d_lock  = lk;
      d_addr  = a;
      d_wdata = wd;
      d_wmask = wm;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_gnt(input string nm, input logic eif, input logic ed);
      chk({nm, "_if_gnt"}, {63'h0, if_gnt}, {63'h0, eif});
      chk({nm, "_d_gnt"}, {63'h0, d_gnt}, {63'h0, ed});
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_if_gnt"}, {63'h0, if_gnt}, 64'h0);
      chk({nm, "_d_gnt"}, {63'h0, d_gnt}, 64'h0);
      chk({nm, "_ram_ren"}, {63'h0, ram_ren}, 64'h0);
      chk({nm, "_ram_wen"}, {63'h0, ram_wen}, 64'h0);
      chk({nm, "_if_rvalid"}, {63'h0, if_rvalid}, 64'h0);
      chk({nm, "_d_rvalid"}, {63'h0, d_rvalid}, 64'h0);
      chk({nm, "_if_rdata"}, {32'h0, if_rdata}, 64'h0);
      chk({nm, "_d_rdata"}, d_rdata, 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with both requests high: nothing may be granted.
      rst = 1'b1;
      set_if(1'b1, 64'h8000_0000);
      set_d(1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h0);
      @(negedge clk);
      chk_all_zero("reset");
      tick();
      tick();
      rst = 1'b0;
      set_if(1'b0, 64'h0);
      set_d(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
      @(negedge clk);
      chk_all_zero("post_reset");
      tick();

      // Lone fetch, upper half of word 0.
      set_if(1'b1, 64'h8000_0004);
      q_if.push_back(32'h1111_2222);
      @(negedge clk);
      chk_gnt("fetch_hi", 1'b1, 1'b0);
      chk("fetch_hi_ren", {63'h0, ram_ren}, 64'h1);
      chk("fetch_hi_ridx", ram_ridx, 64'h0);
      tick();

      // Back-to-back fetch, lower half; address changes right after grant.
      set_if(1'b1, 64'h8000_0000);
      q_if.push_back(32'h3333_4444);
      @(negedge clk);
      chk_gnt("fetch_lo", 1'b1, 1'b0);
      tick();

      // Conflict: data wins for 3 cycles.
      set_if(1'b1, 64'h8000_0000);
      set_d(1'b1, 1'b0, 1'b0, 64'h8000_0010, 64'h0, 64'h0);
      for (int i = 0; i < 3; i++) begin
         q_d.push_back(64'hAAAA_BBBB_CCCC_DDDD);
         @(negedge clk);
         chk_gnt("conflict3", 1'b0, 1'b1);
         chk("conflict3_ridx", ram_ridx, 64'h2);
         tick();
      end

      // Lone fetch, clears any starvation count.
      set_d(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
      set_if(1'b1, 64'h8000_0008);
      q_if.push_back(32'hFFFF_FFFF);
      @(negedge clk);
      chk_gnt("fetch_clear", 1'b1, 1'b0);
      tick();

      // Conflict held 5 cycles.
      set_if(1'b1, 64'h8000_0000);
      set_d(1'b1, 1'b0, 1'b0, 64'h8000_0010, 64'h0, 64'h0);
      for (int i = 0; i < 5; i++) begin
         logic eif;
`ifdef ARB_STARVE_GUARD_EN
         eif = (i == 4);
`else
         eif = 1'b0;
`endif
         if (eif) q_if.push_back(32'h3333_4444);
         else     q_d.push_back(64'hAAAA_BBBB_CCCC_DDDD);
         @(negedge clk);
         chk_gnt("starve", eif, !eif);
         tick();
      end

      // Locked read, then unlocking write, fetch held throughout.
      set_if(1'b1, 64'h8000_0004);
      set_d(1'b1, 1'b0, 1'b1, 64'h8000_0000, 64'h0, 64'h0);
      q_d.push_back(64'h1111_2222_3333_4444);
      @(negedge clk);
      chk_gnt("lock_rd", 1'b0, 1'b1);
      tick();
      set_d(1'b1, 1'b1, 1'b0, 64'h8000_0018, 64'hDEAD_BEEF_0000_0001, '1);
      @(negedge clk);
      chk_gnt("lock_wr", 1'b0, 1'b1);
      chk("lock_wr_wen", {63'h0, ram_wen}, 64'h1);
      chk("lock_wr_widx", ram_widx, 64'h3);
      tick();
      set_d(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
      set_if(1'b1, 64'h8000_001C);
      q_if.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk_gnt("unlock_fetch", 1'b1, 1'b0);
      tick();

      // Masked in-range write, then read back.
      set_if(1'b0, 64'h0);
      set_d(1'b1, 1'b1, 1'b0, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_FFFF_FFFF);
      @(negedge clk);
      chk_gnt("wr_mask", 1'b0, 1'b1);
      chk("wr_mask_wen", {63'h0, ram_wen}, 64'h1);
      chk("wr_mask_widx", ram_widx, 64'h1);
      chk("wr_mask_wdata", ram_wdata, 64'h0123_4567_89AB_CDEF);
      chk("wr_mask_wmask", ram_wmask, 64'h0000_0000_FFFF_FFFF);
      tick();
      set_d(1'b1, 1'b0, 1'b0, 64'h8000_0008, 64'h0, 64'h0);
      q_d.push_back(64'hFFFF_FFFF_89AB_CDEF);
      @(negedge clk);
      chk_gnt("rd_back", 1'b0, 1'b1);
      tick();

      // Out-of-range write and read.
      set_d(1'b1, 1'b1, 1'b0, 64'h1000, 64'h5555_5555_5555_5555, '1);
      @(negedge clk);
      chk_gnt("oor_wr", 1'b0, 1'b1);
      chk("oor_wr_wen", {63'h0, ram_wen}, 64'h0);
      tick();
      set_d(1'b1, 1'b0, 1'b0, 64'h1000, 64'h0, 64'h0);
      q_d.push_back(64'h0);
      @(negedge clk);
      chk_gnt("oor_rd", 1'b0, 1'b1);
      chk("oor_rd_ren", {63'h0, ram_ren}, 64'h0);
      tick();
      set_d(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
      set_if(1'b1, 64'h1004);
      q_if.push_back(32'h0);
      @(negedge clk);
      chk_gnt("oor_fetch", 1'b1, 1'b0);
      chk("oor_fetch_ren", {63'h0, ram_ren}, 64'h0);
      tick();

      // Read grant, then reset next cycle: response dropped.
      set_if(1'b0, 64'h0);
      set_d(1'b1, 1'b0, 1'b0, 64'h8000_0010, 64'h0, 64'h0);
      @(negedge clk);
      chk_gnt("pre_rst_rd", 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_cycle");
      tick();
      rst = 1'b0;
      set_d(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
      @(negedge clk);
      chk_all_zero("after_rst");
      tick();
      tick();

      @(negedge clk);
      chk("if_queue_drained", 64'(q_if.size()), 64'h0);
      chk("d_queue_drained", 64'(q_d.size()), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
